// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-style controller: states,
// opcode/funct fields and ALU control codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_ERR    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU_NONE drives 000 so idle states show all-zero controls.
  typedef enum logic [1:0] {
    ALU_NONE,
    ALU_MODE_ADD,
    ALU_MODE_SUB,
    ALU_MODE_FUNCT
  } alu_mode_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU mode (and Funct for R-type) to ALUControl.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_mode_t   mode,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_ctrl
);

  always_comb begin
    alu_ctrl = 3'b000;
    unique case (mode)
      ALU_NONE:     alu_ctrl = 3'b000;
      ALU_MODE_ADD: alu_ctrl = ALU_ADD;
      ALU_MODE_SUB: alu_ctrl = ALU_SUB;
      ALU_MODE_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle processor control FSM with a bounded memory-wait counter that
// traps into a sticky ERR state on timeout.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State,
  output logic       Error
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          timeout;
  alu_mode_t     alu_mode;

  assign timeout = !MemReady && (wait_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE; else if (timeout) state_d = S_ERR;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB; else if (timeout) state_d = S_ERR;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (MemReady) state_d = S_FETCH; else if (timeout) state_d = S_ERR;
      S_REXEC:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_FETCH;
    endcase
  end

  // Any state change (including entry to a wait state) restarts the count;
  // staying in a wait state only happens while MemReady is low.
  always_comb begin
    wait_d = '0;
    if (state_d == state_q) begin
      if (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR)
        wait_d = wait_q + CW'(1);
      else
        wait_d = wait_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs decode from the current state; PCEn/IRWrite must react to
  // MemReady and Zero within the same cycle, so they are not registered.
  always_comb begin
    PCEn     = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    alu_mode = ALU_NONE;
    unique case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        alu_mode = ALU_MODE_ADD;
        PCEn     = MemReady && rst;
        IRWrite  = MemReady && rst;
      end
      S_DECODE: begin
        ALUSrcB  = 2'b11;
        alu_mode = ALU_MODE_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        alu_mode = ALU_MODE_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA  = 1'b1;
        alu_mode = ALU_MODE_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 1'b1;
        alu_mode = ALU_MODE_SUB;
        PCSrc    = 2'b01;
        PCEn     = Zero;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .mode     (alu_mode),
    .funct    (Funct),
    .alu_ctrl (ALUControl)
  );

  assign State = state_q;
  assign Error = (state_q == S_ERR);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed plus randomized checks of multi_cycle_ctrl against an
// instruction-level model of expected state traces and control words.
module tb_multi_cycle_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic       clk;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic       Error;

  int checks;
  int failures;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
  } step_t;

  step_t exp_q[$];

  multi_cycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .State(State), .Error(Error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Control word order: PCEn IorD MemRead MemWrite IRWrite RegDst MemtoReg
  // RegWrite ALUSrcA ALUSrcB PCSrc ALUControl Error.
  function automatic logic [16:0] ref_ctrl(input int st, input logic mr, input logic z,
                                           input logic [5:0] f, input logic in_reset);
    logic pcen, iord, mrd, mwr, irw, rdst, m2r, rw, asa, err;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, asa, err} = '0;
    asb = 2'b00; pcs = 2'b00; alu = 3'b000;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; alu = 3'b010; pcen = mr && !in_reset; irw = mr && !in_reset; end
      1:  begin asb = 2'b11; alu = 3'b010; end
      2:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; alu = ref_alu(f); end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
      9:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      10: begin rw = 1; end
      11: begin pcs = 2'b10; pcen = 1; end
      12: begin err = 1; end
      default: ;
    endcase
    return {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, pcs, alu, err};
  endfunction

  function automatic logic [16:0] dut_ctrl();
    return {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, PCSrc, ALUControl, Error};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: the model lays out the expected state trace of one instruction
  task automatic push_wait(input int st, input int lows);
    for (int i = 0; i < lows; i++) exp_q.push_back('{st: 4'(st), mr: 1'b0});
    exp_q.push_back('{st: 4'(st), mr: 1'b1});
  endtask

  task automatic push_plain(input int st);
    exp_q.push_back('{st: 4'(st), mr: 1'($urandom_range(0, 1))});
  endtask

  task automatic build(input logic [5:0] op, input int lf, input int lm);
    push_wait(0, lf);
    push_plain(1);
    case (op)
      6'b100011: begin push_plain(2); push_wait(3, lm); push_plain(4); end
      6'b101011: begin push_plain(2); push_wait(5, lm); end
      6'b000000: begin push_plain(6); push_plain(7); end
      6'b000100: push_plain(8);
      6'b001000: begin push_plain(9); push_plain(10); end
      6'b000010: push_plain(11);
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the last step.
  task automatic play(input logic [5:0] op, input logic [5:0] f, input logic z);
    step_t s;
    Op = op; Funct = f; Zero = z;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      MemReady = s.mr;
      #2;
      check("state", 32'(State), 32'(s.st));
      check("ctrl", 32'(dut_ctrl()), 32'(ref_ctrl(int'(s.st), s.mr, z, f, 1'b0)));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                           input int lf, input int lm);
    build(op, lf, lm);
    play(op, f, z);
  endtask

  logic [5:0] op_tab[7];
  logic [5:0] fn_tab[6];

  initial begin
    logic [5:0] op, f;
    checks = 0; failures = 0;
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110011};
    rst = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b1;

    // reset state: FETCH values with PCEn/IRWrite forced low
    #2;
    check("rst_state", 32'(State), 32'd0);
    check("rst_ctrl", 32'(dut_ctrl()), 32'(ref_ctrl(0, 1'b1, 1'b0, 6'd0, 1'b1)));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run_instr(6'b100011, 6'd0, 1'b0, 0, 0);   // lw, MemReady at once
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0);   // beq taken
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0);   // beq not taken
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);  // slt
    run_instr(6'b101011, 6'd0, 1'b0, 0, 3);   // sw, 3 wait cycles
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0);   // NOP opcode
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0);
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0);
    // MemReady on the last allowed cycle wins
    run_instr(6'b100011, 6'd0, 1'b0, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1);
    run_instr(6'b101011, 6'd0, 1'b0, 2, MEM_TIMEOUT - 1);

    for (int n = 0; n < 40; n++) begin
      op = op_tab[$urandom_range(0, 6)];
      f  = fn_tab[$urandom_range(0, 5)];
      run_instr(op, f, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    // reset in the middle of a load's memory read
    Op = 6'b100011; Funct = '0;
    exp_q.push_back('{st: 4'd0, mr: 1'b1});
    exp_q.push_back('{st: 4'd1, mr: 1'b0});
    exp_q.push_back('{st: 4'd2, mr: 1'b0});
    exp_q.push_back('{st: 4'd3, mr: 1'b0});
    exp_q.push_back('{st: 4'd3, mr: 1'b0});
    play(6'b100011, 6'd0, 1'b0);
    MemReady = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("midrd_rst_state", 32'(State), 32'd0);
    check("midrd_rst_ctrl", 32'(dut_ctrl()), 32'(ref_ctrl(0, 1'b0, 1'b0, 6'd0, 1'b1)));
    @(posedge clk); #1 rst = 1'b1;
    // fresh counter: the full FETCH budget is available again
    run_instr(6'b100011, 6'd0, 1'b0, MEM_TIMEOUT - 1, 0);

    // FETCH timeout
    Op = 6'b000000; MemReady = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #2 check("to_wait_state", 32'(State), 32'd0);
      @(posedge clk); #1;
    end
    #2;
    check("to_err_state", 32'(State), 32'd12);
    check("to_err_ctrl", 32'(dut_ctrl()), 32'(ref_ctrl(12, 1'b0, 1'b0, 6'd0, 1'b0)));
    MemReady = 1'b1; Zero = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky_state", 32'(State), 32'd12);
    check("err_sticky_flag", 32'(Error), 32'd1);
    rst = 1'b0;
    #1;
    check("err_rst_state", 32'(State), 32'd0);
    check("err_rst_flag", 32'(Error), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    Zero = 1'b0;
    run_instr(6'b000000, 6'b100010, 1'b0, 1, 0);

    #2 check("final_state", 32'(State), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
